ovr_ctrl_reg: RTL and testbench
===============================

// Module: ovr_ctrl_reg
// PURPOSE
// - Synthesizable register with assign/deassign/force/release semantics, driven by a command port.
// - Honours the override commands that testbench code issues procedurally with assign/force.
// - Sits between a command master (bench sequencer or debug bus) and the logic that consumes q.
// - Override precedence: force > assign > normal write.
// PARAMETERS
// - W          default 2      data width of q and cmd_data
// - RESET_VAL  default 2'b00  value of the base register after reset (W bits)
// - SETTLE     default 2      cycles cmd_ready stays low after ASSIGN/DEASSIGN/FORCE/RELEASE (0 = none)
// PORTS
// - clk         in   1   clock, rising edge
// - rst         in   1   asynchronous reset, active-high
// - cmd_valid   in   1   command request
// - cmd_ready   out  1   block can accept a command
// - cmd_op      in   3   0=WRITE 1=ASSIGN 2=DEASSIGN 3=FORCE 4=RELEASE; 5-7 illegal
// - cmd_data    in   W   operand for WRITE/ASSIGN/FORCE (ignored otherwise)
// - q           out  W   effective register value
// - ovr_state   out  2   {forced, assigned}
// - write_lost  out  1   one-cycle pulse: WRITE accepted while assigned or forced
// - err         out  1   one-cycle pulse: illegal op, DEASSIGN when not assigned, RELEASE when not forced
// - ovr_cycles  out  16  (OVR_CYCLES_EN only) cycles with forced or assigned set in current override episode
// BEHAVIOUR
// - Accept: cmd_valid & cmd_ready at a rising edge; one command per cycle; q and flags update at that edge.
// - Reset (async, any time, including mid-settle): base=RESET_VAL, asg_val=frc_val=0,
//   assigned=forced=0, q=RESET_VAL, cmd_ready=1, write_lost=err=0, settle count=0, ovr_cycles=0.
// - q = forced ? frc_val : assigned ? asg_val : base; registered, 1-cycle latency from accept.
// - States: NORMAL(00), ASSIGNED(01), FORCED(10), FORCED_ASG(11).
// - WRITE: NORMAL -> base<=cmd_data. Any other state -> discarded, write_lost=1, state unchanged.
// - ASSIGN: asg_val<=cmd_data, assigned<=1. Re-ASSIGN updates the value.
//   From FORCED, q remains frc_val.
// - DEASSIGN: assigned set -> base<=asg_val (value persists), assigned<=0.
//   In FORCED_ASG, q is unchanged until RELEASE.
// - FORCE: frc_val<=cmd_data, forced<=1. Re-FORCE updates the value.
// - RELEASE: forced set -> forced<=0.
//   If assigned, q returns to asg_val; else base<=frc_val (forced value persists).
// - err cases: illegal op (5-7), DEASSIGN when not assigned, RELEASE when not forced.
//   The command is still consumed, state and data are unchanged, and SETTLE is not started.
// - Settle: a successful ASSIGN/DEASSIGN/FORCE/RELEASE loads the counter with SETTLE.
//   cmd_ready=0 while counter != 0, decrementing each cycle.
//   WRITE and err commands do not start a settle period.
// - cmd_valid while cmd_ready=0: ignored; the master holds cmd_op/cmd_data until accepted.
// CONFIGURATION
// - OVR_CYCLES_EN defined: ovr_cycles port exists.
//   Counts +1 per cycle while ovr_state!=00 and saturates at 16'hFFFF.
//   Clears on the edge where ovr_state goes from 00 to non-00, and on rst.
//   Holds its value after return to 00.
// - OVR_CYCLES_EN undefined: port and counter are absent; all other behaviour is identical.
// TESTING (W=2, SETTLE=2)
// - rst, then WRITE 00 -> q=00, ovr_state=00, cmd_ready=1, no pulses.
// - ASSIGN 01 -> q=01, ovr_state=01; cmd_ready low 2 cycles.
//   WRITE 10 -> write_lost=1, q=01.
// - DEASSIGN -> q stays 01, ovr_state=00.
//   WRITE 10 -> q=10, write_lost=0.
// - ASSIGN 10, FORCE 11 -> q=11, ovr_state=11.
//   RELEASE -> q=10, ovr_state=01.
//   DEASSIGN -> q=10, ovr_state=00.
// - FORCE 11 from NORMAL, RELEASE -> q stays 11.
//   Second RELEASE -> err=1, q=11, cmd_ready stays 1.
// - rst asserted mid-settle after FORCE 11 -> q=00, cmd_ready=1, ovr_state=00 immediately.
//   op=6 -> err=1.

Source files
------------

// File: rtl/ovr_ctrl_reg.sv
// Command-driven register with write/assign/deassign/force/release override semantics.
// Optional OVR_CYCLES_EN adds an override-episode cycle counter on port ovr_cycles.
module ovr_ctrl_reg #(
   parameter int             W         = 2,
   parameter logic [W-1:0]   RESET_VAL = '0,
   parameter int             SETTLE    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_op,
   input  logic [W-1:0]  cmd_data,
   output logic [W-1:0]  q,
   output logic [1:0]    ovr_state,
   output logic          write_lost,
`ifdef OVR_CYCLES_EN
   output logic          err,
   output logic [15:0]   ovr_cycles
`else
   output logic          err
`endif
);

   // state      | meaning
   // NORMAL     | q follows base, writes land
   // ASSIGNED   | q = asg_val, writes lost
   // FORCED     | q = frc_val, writes lost
   // FORCED_ASG | forced over an assign; q = frc_val
   typedef enum logic [1:0] {
      NORMAL     = 2'b00,
      ASSIGNED   = 2'b01,
      FORCED     = 2'b10,
      FORCED_ASG = 2'b11
   } state_t;

   localparam logic [2:0] OP_WRITE    = 3'd0;
   localparam logic [2:0] OP_ASSIGN   = 3'd1;
   localparam logic [2:0] OP_DEASSIGN = 3'd2;
   localparam logic [2:0] OP_FORCE    = 3'd3;
   localparam logic [2:0] OP_RELEASE  = 3'd4;
   localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   state_t          state, state_n;
   logic [W-1:0]    base, base_n, asg_val, asg_n, frc_val, frc_n, q_n;
   logic [CW-1:0]   settle_cnt;
   logic            accept, settle_start, wl_n, err_n;

   assign accept    = cmd_valid & cmd_ready;
   assign cmd_ready = (settle_cnt == '0);
   assign ovr_state = state;

   always_comb begin
      state_n      = state;
      base_n       = base;
      asg_n        = asg_val;
      frc_n        = frc_val;
      wl_n         = 1'b0;
      err_n        = 1'b0;
      settle_start = 1'b0;
      if (accept) begin
         case (cmd_op)
            OP_WRITE: begin
               if (state == NORMAL) base_n = cmd_data;
               else                 wl_n   = 1'b1;
            end
            OP_ASSIGN: begin
               asg_n        = cmd_data;
               state_n      = state_t'({state[1], 1'b1});
               settle_start = 1'b1;
            end
            OP_DEASSIGN: begin
               if (state[0]) begin
                  base_n       = asg_val;
                  state_n      = state_t'({state[1], 1'b0});
                  settle_start = 1'b1;
               end else begin
                  err_n = 1'b1;
               end
            end
            OP_FORCE: begin
               frc_n        = cmd_data;
               state_n      = state_t'({1'b1, state[0]});
               settle_start = 1'b1;
            end
            OP_RELEASE: begin
               if (state[1]) begin
                  // with no assign underneath, the forced value becomes the stored value
                  if (!state[0]) base_n = frc_val;
                  state_n      = state_t'({1'b0, state[0]});
                  settle_start = 1'b1;
               end else begin
                  err_n = 1'b1;
               end
            end
            default: err_n = 1'b1;
         endcase
      end
      q_n = state_n[1] ? frc_n : (state_n[0] ? asg_n : base_n);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= NORMAL;
         base       <= RESET_VAL;
         asg_val    <= '0;
         frc_val    <= '0;
         q          <= RESET_VAL;
         write_lost <= 1'b0;
         err        <= 1'b0;
         settle_cnt <= '0;
      end else begin
         state      <= state_n;
         base       <= base_n;
         asg_val    <= asg_n;
         frc_val    <= frc_n;
         q          <= q_n;
         write_lost <= wl_n;
         err        <= err_n;
         if (settle_start)          settle_cnt <= CW'(SETTLE);
         else if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
      end
   end

`ifdef OVR_CYCLES_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovr_cycles <= '0;
      end else if (state == NORMAL && state_n != NORMAL) begin
         ovr_cycles <= '0;
      end else if (state != NORMAL && ovr_cycles != 16'hFFFF) begin
         ovr_cycles <= ovr_cycles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ovr_ctrl_reg.sv
// Directed bench for ovr_ctrl_reg (W=2, SETTLE=2) with hand-computed expectations.
module tb_ovr_ctrl_reg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = 3'd0;
   logic [1:0]  cmd_data = 2'd0;
   logic [1:0]  q;
   logic [1:0]  ovr_state;
   logic        write_lost;
   logic        err;
`ifdef OVR_CYCLES_EN
   logic [15:0] ovr_cycles;
`endif

   int errors = 0;
   int checks = 0;

   ovr_ctrl_reg #(.W(2), .RESET_VAL(2'b00), .SETTLE(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_data   (cmd_data),
      .q          (q),
      .ovr_state  (ovr_state),
      .write_lost (write_lost),
`ifdef OVR_CYCLES_EN
      .err        (err),
      .ovr_cycles (ovr_cycles)
`else
      .err        (err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // drives one command once the block is ready; returns 1 ns after the accepting edge
   task automatic send(input logic [2:0] op, input logic [1:0] d);
      int n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) check("ready_timeout", 16'(cmd_ready), 16'd1);
      cmd_op    = op;
      cmd_data  = d;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_q", 16'(q), 16'd0);
      check("rst_ovr", 16'(ovr_state), 16'd0);
      check("rst_ready", 16'(cmd_ready), 16'd1);
      check("rst_wl", 16'(write_lost), 16'd0);
      check("rst_err", 16'(err), 16'd0);
      @(negedge clk);
      rst = 1'b0;

      send(3'd0, 2'b00);
      check("wr0_q", 16'(q), 16'd0);
      check("wr0_ovr", 16'(ovr_state), 16'd0);
      check("wr0_ready", 16'(cmd_ready), 16'd1);
      check("wr0_wl", 16'(write_lost), 16'd0);
      check("wr0_err", 16'(err), 16'd0);

      send(3'd1, 2'b01);
      check("asg_q", 16'(q), 16'd1);
      check("asg_ovr", 16'(ovr_state), 16'd1);
      check("asg_rdy0", 16'(cmd_ready), 16'd0);
      @(posedge clk); #1;
      check("asg_rdy1", 16'(cmd_ready), 16'd0);
      @(posedge clk); #1;
      check("asg_rdy2", 16'(cmd_ready), 16'd1);

      send(3'd0, 2'b10);
      check("wrasg_wl", 16'(write_lost), 16'd1);
      check("wrasg_q", 16'(q), 16'd1);
      check("wrasg_ready", 16'(cmd_ready), 16'd1);
      @(posedge clk); #1;
      check("wrasg_wl_pulse", 16'(write_lost), 16'd0);

      send(3'd2, 2'b00);
      check("deasg_q", 16'(q), 16'd1);
      check("deasg_ovr", 16'(ovr_state), 16'd0);
      send(3'd0, 2'b10);
      check("wr2_q", 16'(q), 16'd2);
      check("wr2_wl", 16'(write_lost), 16'd0);

      send(3'd1, 2'b10);
      check("asg2_q", 16'(q), 16'd2);
      send(3'd3, 2'b11);
      check("frc_q", 16'(q), 16'd3);
      check("frc_ovr", 16'(ovr_state), 16'd3);
      send(3'd2, 2'b00);
      check("deasg_frc_q", 16'(q), 16'd3);
      check("deasg_frc_ovr", 16'(ovr_state), 16'd2);
      send(3'd1, 2'b10);
      check("reasg_frc_q", 16'(q), 16'd3);
      send(3'd4, 2'b00);
      check("rel_asg_q", 16'(q), 16'd2);
      check("rel_asg_ovr", 16'(ovr_state), 16'd1);
      send(3'd2, 2'b00);
      check("deasg3_q", 16'(q), 16'd2);
      check("deasg3_ovr", 16'(ovr_state), 16'd0);

      send(3'd3, 2'b11);
      check("frc2_ovr", 16'(ovr_state), 16'd2);
      send(3'd0, 2'b01);
      check("wrfrc_wl", 16'(write_lost), 16'd1);
      check("wrfrc_q", 16'(q), 16'd3);
      send(3'd4, 2'b00);
      check("rel_q", 16'(q), 16'd3);
      check("rel_ovr", 16'(ovr_state), 16'd0);
      send(3'd4, 2'b00);
      check("rel2_err", 16'(err), 16'd1);
      check("rel2_q", 16'(q), 16'd3);
      check("rel2_ready", 16'(cmd_ready), 16'd1);
      send(3'd2, 2'b00);
      check("deasg_norm_err", 16'(err), 16'd1);
      check("deasg_norm_ready", 16'(cmd_ready), 16'd1);
      send(3'd0, 2'b01);
      check("wr1_q", 16'(q), 16'd1);
      check("wr1_err", 16'(err), 16'd0);

      send(3'd3, 2'b11);
      check("frc3_ready", 16'(cmd_ready), 16'd0);
      rst = 1'b1;
      #1;
      check("arst_q", 16'(q), 16'd0);
      check("arst_ready", 16'(cmd_ready), 16'd1);
      check("arst_ovr", 16'(ovr_state), 16'd0);
      @(negedge clk);
      rst = 1'b0;

      send(3'd6, 2'b11);
      check("ill_err", 16'(err), 16'd1);
      check("ill_q", 16'(q), 16'd0);
      check("ill_ovr", 16'(ovr_state), 16'd0);
      check("ill_ready", 16'(cmd_ready), 16'd1);
      @(posedge clk); #1;
      check("ill_err_pulse", 16'(err), 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
